mem_stage: RTL

//  MEM pipeline stage. Sits between EX (which issues data-SRAM requests) and WB.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_load_ext.sv | 36 +++
 rtl/mem_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus field offsets, load opcodes, slot state.
package mem_stage_pkg;

    localparam int unsigned PASS_W_DEF    = 78;
    // Position of the ertn flag inside the CSR/exception passthrough field
    localparam int unsigned PASS_ERTN_BIT = 0;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_H    = 3'd2;
    localparam logic [2:0] LD_W    = 3'd3;
    localparam logic [2:0] LD_BU   = 3'd4;
    localparam logic [2:0] LD_HU   = 3'd5;

    // EX->MEM bus field offsets, LSB first
    localparam int unsigned EX_PC_LSB    = 0;
    localparam int unsigned EX_ALU_LSB   = 32;
    localparam int unsigned EX_WADDR_LSB = 64;
    localparam int unsigned EX_WE_BIT    = 69;
    localparam int unsigned EX_LDOP_LSB  = 70;
    localparam int unsigned EX_REQ_BIT   = 73;
    localparam int unsigned EX_EXCEP_BIT = 74;
    localparam int unsigned EX_PASS_LSB  = 75;

    typedef enum logic [1:0] {
        StEmpty,
        StWait,
        StDone
    } mem_state_e;

    function automatic logic is_load(input logic [2:0] ld_op);
        return (ld_op != LD_NONE) && (ld_op <= LD_HU);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Byte/half selection and sign/zero extension of a 32-bit load response.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        half_sel = '0;
        ext_o    = rdata_i;
        unique case (addr_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = '0;
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (ld_op_i)
            LD_B:    ext_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_o = {24'd0, byte_sel};
            LD_H:    ext_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_o = {16'd0, half_sel};
            LD_W:    ext_o = rdata_i;
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, extends loads, forwards to ID, feeds WB.
// Optional MEM_LOAD_FWD_EN: forward extended rdata to ID combinationally on the data_ok cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned PASS_W = PASS_W_DEF,
    parameter int unsigned DROP_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_to_mem_valid,
    input  logic [PASS_W+74:0] ex_to_mem_bus,
    output logic              mem_allowin,
    output logic              mem_to_wb_valid,
    output logic [PASS_W+70:0] mem_to_wb_bus,
    input  logic              wb_allowin,
    input  logic              wb_flush,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic [38:0]       mem_to_id_bus,
    output logic              mem_to_ex_bus
);

    mem_state_e          state_q, state_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                excep_q, excep_d;
    logic [2:0]          ld_op_q, ld_op_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          waddr_q, waddr_d;
    logic [31:0]         alu_q, alu_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic        mem_valid, resp_ok, ready_go, accept;
    logic        ex_req, ex_excep;
    logic [31:0] load_src, load_ext, wdata;
    logic        id_we, id_avail, ld_block;
    logic [31:0] id_wdata;

    assign ex_req   = ex_to_mem_bus[EX_REQ_BIT];
    assign ex_excep = ex_to_mem_bus[EX_EXCEP_BIT];

    assign mem_valid       = state_q != StEmpty;
    // A response only belongs to this slot once all stale responses are drained
    assign resp_ok         = (state_q == StWait) & data_sram_data_ok & (drop_q == '0);
    assign ready_go        = (state_q == StDone) | resp_ok;
    assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
    assign accept          = ex_to_mem_valid & mem_allowin & ~wb_flush;
    assign mem_to_wb_valid = mem_valid & ready_go & ~wb_flush;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        excep_d = excep_q;
        ld_op_d = ld_op_q;
        rf_we_d = rf_we_q;
        waddr_d = waddr_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        drop_d  = drop_q;

        if (resp_ok) begin
            rdata_d = data_sram_rdata;
        end

        if (wb_flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = (ex_req & ~ex_excep) ? StWait : StDone;
            pass_d  = ex_to_mem_bus[EX_PASS_LSB +: PASS_W];
            excep_d = ex_excep;
            ld_op_d = ex_to_mem_bus[EX_LDOP_LSB +: 3];
            rf_we_d = ex_to_mem_bus[EX_WE_BIT];
            waddr_d = ex_to_mem_bus[EX_WADDR_LSB +: 5];
            alu_d   = ex_to_mem_bus[EX_ALU_LSB +: 32];
            pc_d    = ex_to_mem_bus[EX_PC_LSB +: 32];
        end else if (ready_go & wb_allowin) begin
            state_d = StEmpty;
        end else if (resp_ok) begin
            state_d = StDone;
        end

        if (wb_flush & (state_q == StWait) & ~data_sram_data_ok) begin
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (data_sram_data_ok & (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            pass_q  <= '0;
            excep_q <= 1'b0;
            ld_op_q <= LD_NONE;
            rf_we_q <= 1'b0;
            waddr_q <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            excep_q <= excep_d;
            ld_op_q <= ld_op_d;
            rf_we_q <= rf_we_d;
            waddr_q <= waddr_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

    // While waiting, the live response is the only valid data source
    assign load_src = (state_q == StWait) ? data_sram_rdata : rdata_q;

    mem_load_ext u_load_ext (
        .ld_op_i (ld_op_q),
        .addr_i  (alu_q[1:0]),
        .rdata_i (load_src),
        .ext_o   (load_ext)
    );

    assign wdata         = is_load(ld_op_q) ? load_ext : alu_q;
    assign mem_to_wb_bus = {pass_q, excep_q, rf_we_q, waddr_q, wdata, pc_q};

    assign id_we = mem_valid & rf_we_q & ~excep_q;

`ifdef MEM_LOAD_FWD_EN
    assign id_avail = ready_go;
    assign id_wdata = wdata;
`else
    logic [31:0] hold_ext;

    mem_load_ext u_hold_ext (
        .ld_op_i (ld_op_q),
        .addr_i  (alu_q[1:0]),
        .rdata_i (rdata_q),
        .ext_o   (hold_ext)
    );

    assign id_avail = state_q == StDone;
    assign id_wdata = is_load(ld_op_q) ? hold_ext : alu_q;
`endif

    assign ld_block      = id_we & is_load(ld_op_q) & ~id_avail;
    assign mem_to_id_bus = {ld_block, id_we, waddr_q, id_wdata};
    assign mem_to_ex_bus = mem_valid & (excep_q | pass_q[PASS_ERTN_BIT]);

endmodule
